cu_sequencer: RTL and testbench

- Multi-cycle control sequencer for the RV32I core; the successor to the single-cycle combinational control word.
- Steps each instruction through FETCH, DECODE, EXEC, MEM and WB, and drives the per-phase control fields (alu_in_a, alu_in_b, alu_mode, dest_reg_from, pc_src, pc_load, dbus_we, dbus_re).
- Adds ibus/dbus ready handshakes, a parametrised bus-timeout watchdog, and a sticky trap state for illegal opcodes and bus timeouts.

---
 rtl/cu_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_cu_sequencer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/cu_sequencer.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB with bus
// ready handshakes, a wait-state watchdog and a sticky TRAP state.
module cu_sequencer #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ibus_ready,
  input  logic       dbus_ready,
  input  logic [6:0] opcode,
  input  logic       branch_taken,
  output logic       ibus_re,
  output logic       ir_load,
  output logic       alu_in_a,
  output logic       alu_in_b,
  output logic       alu_mode,
  output logic [1:0] dest_reg_from,
  output logic       reg_we,
  output logic       pc_src,
  output logic       pc_load,
  output logic       dbus_re,
  output logic       dbus_we,
  output logic       illegal,
  output logic       bus_err,
  output logic       halted
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_e;

  typedef enum logic [1:0] {
    DEST_NONE = 2'd0, DEST_ALU = 2'd1, DEST_MEM = 2'd2, DEST_PC = 2'd3
  } dest_e;

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_ALUI   = 7'h13;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_ALU    = 7'h33;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_JAL    = 7'h6F;

  localparam bit             WD_EN   = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

  state_e           state, state_nx;
  logic [6:0]       op_q, op_nx;
  logic [CNT_W-1:0] wait_cnt, cnt_nx;
  logic             taken_q, taken_nx;
  logic             illegal_q, illegal_nx;
  logic             bus_err_q, bus_err_nx;
  logic             wd_hit;

  logic             ibus_req, dbus_rd_req, dbus_wr_req;
  dest_e            dest;

  function automatic logic is_known(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_ALUI, OP_AUIPC, OP_STORE, OP_ALU,
      OP_LUI, OP_BRANCH, OP_JALR, OP_JAL: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_FETCH;
      op_q      <= '0;
      wait_cnt  <= '0;
      taken_q   <= 1'b0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state     <= state_nx;
      op_q      <= op_nx;
      wait_cnt  <= cnt_nx;
      taken_q   <= taken_nx;
      illegal_q <= illegal_nx;
      bus_err_q <= bus_err_nx;
    end
  end

  assign wd_hit = WD_EN && (wait_cnt == WD_LAST);

  // NOTE: every variable gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nx   = state;
    op_nx      = op_q;
    cnt_nx     = wait_cnt;
    taken_nx   = taken_q;
    illegal_nx = illegal_q;
    bus_err_nx = bus_err_q;
    case (state)
      S_FETCH: begin
        if (ibus_ready) begin
          state_nx = S_DECODE;
          cnt_nx   = '0;
        end else if (wd_hit) begin
          state_nx   = S_TRAP;
          bus_err_nx = 1'b1;
        end else begin
          cnt_nx = wait_cnt + 1'b1;
        end
      end
      S_DECODE: begin
        op_nx = opcode;
        if (is_known(opcode)) begin
          state_nx = S_EXEC;
        end else begin
          state_nx   = S_TRAP;
          illegal_nx = 1'b1;
        end
      end
      S_EXEC: begin
        taken_nx = (op_q == OP_BRANCH) && branch_taken;
        state_nx = (op_q == OP_LOAD || op_q == OP_STORE) ? S_MEM : S_WB;
      end
      S_MEM: begin
        if (dbus_ready) begin
          state_nx = S_WB;
          cnt_nx   = '0;
        end else if (wd_hit) begin
          state_nx   = S_TRAP;
          bus_err_nx = 1'b1;
        end else begin
          cnt_nx = wait_cnt + 1'b1;
        end
      end
      S_WB:    state_nx = S_FETCH;
      S_TRAP:  state_nx = S_TRAP;
      default: state_nx = S_TRAP;
    endcase
  end

  // Moore control word decoded from state and the latched opcode only.
  always_comb begin
    ibus_req    = 1'b0;
    dbus_rd_req = 1'b0;
    dbus_wr_req = 1'b0;
    alu_in_a    = 1'b0;
    alu_in_b    = 1'b0;
    alu_mode    = 1'b0;
    dest        = DEST_NONE;
    pc_src      = 1'b0;
    pc_load     = 1'b0;
    halted      = 1'b0;

    if (state == S_EXEC || state == S_MEM || state == S_WB) begin
      case (op_q)
        OP_ALUI: alu_in_b = 1'b1;
        OP_LOAD, OP_STORE, OP_JALR, OP_LUI: begin
          alu_in_b = 1'b1;
          alu_mode = 1'b1;
        end
        OP_BRANCH, OP_JAL, OP_AUIPC: begin
          alu_in_a = 1'b1;
          alu_in_b = 1'b1;
          alu_mode = 1'b1;
        end
        default: ;
      endcase
    end

    case (state)
      S_FETCH: ibus_req = 1'b1;
      S_MEM: begin
        dbus_rd_req = (op_q == OP_LOAD);
        dbus_wr_req = (op_q == OP_STORE);
      end
      S_WB: begin
        pc_load = 1'b1;
        pc_src  = (op_q == OP_JAL) || (op_q == OP_JALR) ||
                  ((op_q == OP_BRANCH) && taken_q);
        case (op_q)
          OP_ALU, OP_ALUI, OP_LUI, OP_AUIPC: dest = DEST_ALU;
          OP_LOAD:                           dest = DEST_MEM;
          OP_JAL, OP_JALR:                   dest = DEST_PC;
          default:                           dest = DEST_NONE;
        endcase
      end
      S_TRAP:  halted = 1'b1;
      default: ;
    endcase
  end

  // Bus requests are gated by rst_n so they drop the instant reset asserts.
  assign ibus_re       = ibus_req & rst_n;
  assign dbus_re       = dbus_rd_req & rst_n;
  assign dbus_we       = dbus_wr_req & rst_n;
  assign ir_load       = ibus_re & ibus_ready;
  assign dest_reg_from = dest;
  assign reg_we        = (dest != DEST_NONE);
  assign illegal       = illegal_q;
  assign bus_err       = bus_err_q;

endmodule

// File: tb/tb_cu_sequencer.sv
// Directed testbench for cu_sequencer: hand-computed control words checked
// one cycle at a time, 1 ns after each rising edge.
module tb_cu_sequencer;

  logic       clk, rst_n;
  logic       ibus_ready, dbus_ready, branch_taken;
  logic [6:0] opcode;
  logic       ibus_re, ir_load, alu_in_a, alu_in_b, alu_mode;
  logic [1:0] dest_reg_from;
  logic       reg_we, pc_src, pc_load, dbus_re, dbus_we;
  logic       illegal, bus_err, halted;

  int n_cmp = 0;
  int n_err = 0;

  cu_sequencer #(.TIMEOUT(16), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .ibus_ready(ibus_ready), .dbus_ready(dbus_ready),
    .opcode(opcode), .branch_taken(branch_taken),
    .ibus_re(ibus_re), .ir_load(ir_load),
    .alu_in_a(alu_in_a), .alu_in_b(alu_in_b), .alu_mode(alu_mode),
    .dest_reg_from(dest_reg_from), .reg_we(reg_we),
    .pc_src(pc_src), .pc_load(pc_load),
    .dbus_re(dbus_re), .dbus_we(dbus_we),
    .illegal(illegal), .bus_err(bus_err), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [14:0] ctrl;
  assign ctrl = {ibus_re, ir_load, alu_in_a, alu_in_b, alu_mode, dest_reg_from,
                 reg_we, pc_src, pc_load, dbus_re, dbus_we, illegal, bus_err, halted};

  function automatic logic [14:0] cw(
    input logic ire, irl, a, b, m, input logic [1:0] d,
    input logic we, src, ld, dre, dwe, ill, be, hlt);
    return {ire, irl, a, b, m, d, we, src, ld, dre, dwe, ill, be, hlt};
  endfunction

  task automatic check(input string tag, input logic [14:0] got, input logic [14:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    #1;
  endtask

  logic [14:0] f_idle, f_ld, idle0, trap_ill, trap_be;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    f_idle   = cw(1,0,0,0,0,2'd0,0,0,0,0,0,0,0,0);
    f_ld     = cw(1,1,0,0,0,2'd0,0,0,0,0,0,0,0,0);
    idle0    = 15'd0;
    trap_ill = cw(0,0,0,0,0,2'd0,0,0,0,0,0,1,0,1);
    trap_be  = cw(0,0,0,0,0,2'd0,0,0,0,0,0,0,1,1);

    rst_n = 1'b0; ibus_ready = 1'b0; dbus_ready = 1'b0;
    branch_taken = 1'b0; opcode = 7'h00;
    #1;
    check("rst_held", ctrl, idle0);
    tick();
    rst_n = 1'b1;
    #1;
    check("rst_fetch", ctrl, f_idle);

    // ALU, zero wait states
    ibus_ready = 1'b1; opcode = 7'h33; #1;
    check("alu_f", ctrl, f_ld);
    tick(); ibus_ready = 1'b0; #1;
    check("alu_d", ctrl, idle0);
    tick(); check("alu_e", ctrl, idle0);
    tick(); check("alu_w", ctrl, cw(0,0,0,0,0,2'd1,1,0,1,0,0,0,0,0));
    tick(); check("alu_next_f", ctrl, f_idle);

    // LOAD with dbus_ready low for three MEM cycles
    ibus_ready = 1'b1; opcode = 7'h03; #1;
    check("ld_f", ctrl, f_ld);
    tick(); ibus_ready = 1'b0; #1;
    check("ld_d", ctrl, idle0);
    tick(); check("ld_e", ctrl, cw(0,0,0,1,1,2'd0,0,0,0,0,0,0,0,0));
    for (int i = 0; i < 4; i++) begin
      tick(); check("ld_mem", ctrl, cw(0,0,0,1,1,2'd0,0,0,0,1,0,0,0,0));
    end
    dbus_ready = 1'b1;
    tick(); dbus_ready = 1'b0;
    check("ld_w", ctrl, cw(0,0,0,1,1,2'd2,1,0,1,0,0,0,0,0));
    tick(); check("ld_next_f", ctrl, f_idle);

    // BRANCH taken, then not taken
    for (int t = 1; t >= 0; t--) begin
      ibus_ready = 1'b1; opcode = 7'h63;
      tick(); ibus_ready = 1'b0;
      tick(); branch_taken = t[0]; #1;
      check("br_e", ctrl, cw(0,0,1,1,1,2'd0,0,0,0,0,0,0,0,0));
      tick(); branch_taken = 1'b0;
      check(t ? "br_taken_w" : "br_nt_w", ctrl, cw(0,0,1,1,1,2'd0,0,t[0],1,0,0,0,0,0));
      tick(); check("br_next_f", ctrl, f_idle);
    end

    // JAL
    ibus_ready = 1'b1; opcode = 7'h6F;
    tick(); ibus_ready = 1'b0;
    tick(); check("jal_e", ctrl, cw(0,0,1,1,1,2'd0,0,0,0,0,0,0,0,0));
    tick(); check("jal_w", ctrl, cw(0,0,1,1,1,2'd3,1,1,1,0,0,0,0,0));
    tick(); check("jal_next_f", ctrl, f_idle);

    // STORE interrupted by reset while the write request is outstanding
    ibus_ready = 1'b1; opcode = 7'h23;
    tick(); ibus_ready = 1'b0;
    tick(); tick();
    check("st_mem", ctrl, cw(0,0,0,1,1,2'd0,0,0,0,0,1,0,0,0));
    #2; rst_n = 1'b0; #1;
    check("st_rst_async", ctrl, idle0);
    rst_n = 1'b1; #1;
    check("st_rst_fetch", ctrl, f_idle);

    // Watchdog: 16 not-ready FETCH cycles trap
    repeat (15) tick();
    check("wd_last_fetch", ctrl, f_idle);
    tick(); check("wd_trap", ctrl, trap_be);
    reset_pulse();
    check("wd_rst_fetch", ctrl, f_idle);

    // Watchdog: ready on the 16th cycle wins
    repeat (15) tick();
    ibus_ready = 1'b1; opcode = 7'h33; #1;
    check("wd_ready_f", ctrl, f_ld);
    tick(); ibus_ready = 1'b0; #1;
    check("wd_ready_d", ctrl, idle0);
    tick(); tick(); tick();
    check("wd_ready_next_f", ctrl, f_idle);

    // Illegal opcode: sticky trap until reset
    ibus_ready = 1'b1; opcode = 7'h7F;
    tick(); ibus_ready = 1'b0; #1;
    check("ill_d", ctrl, idle0);
    tick(); check("ill_trap", ctrl, trap_ill);
    for (int i = 0; i < 20; i++) begin
      ibus_ready = 1'b1; dbus_ready = i[0];
      tick(); check("ill_hold", ctrl, trap_ill);
    end
    ibus_ready = 1'b0; dbus_ready = 1'b0;
    reset_pulse();
    check("ill_rst_fetch", ctrl, f_idle);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
